attention_av_multiply: RTL and testbench
========================================

Name: attention_av_multiply

Overview:
- Stage directly downstream of softmax_approx: consumes normalized attention weights A (L,N,L) and value matrix V (L,N,E), produces context O = A·V of shape (L,N,E) per head.
- Sequential single-MAC datapath driven by an FSM. One multiply-accumulate per cycle, iterating row i, head n, output column e, reduction index j.
- Output feeds the head-concat/output-projection stage.

Parameters:
- DATA_WIDTH, 16, element width for A, V and O.
- L, 8, sequence length; must be >= 2.
- N, 1, number of heads; must be >= 1.
- E, 8, per-head value dimension; must be >= 2.
- FRAC_BITS, 8, fractional bits of the fixed-point format for A, V and O.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin an operation; sampled only in S_IDLE.
- A_in  input  DATA_WIDTH*L*N*L  weights, unsigned; element [i][n][j] at bit offset ((i*N*L)+(n*L)+j)*DATA_WIDTH.
- V_in  input  DATA_WIDTH*L*N*E  values, signed two's complement; element [j][n][e] at offset ((j*N*E)+(n*E)+e)*DATA_WIDTH.
- out_mat  output  DATA_WIDTH*L*N*E  context, signed; element [i][n][e] at offset ((i*N*E)+(n*E)+e)*DATA_WIDTH.
- done  output  1  one-cycle completion pulse.
- out_valid  output  1  level; out_mat holds a complete result.

Behaviour:
- Reset (asynchronous, rst=1): state=S_IDLE, all counters 0, accumulator 0, out_mat=0, done=0, out_valid=0.
- States: S_IDLE, S_LOAD, S_COMPUTE, S_OUTPUT, S_DONE.
- S_IDLE: when start=1, go to S_LOAD and clear out_valid.
- start is ignored in every state except S_IDLE. No queuing.
- S_LOAD: lasts 1 cycle. Capture A_in and V_in into internal arrays. Inputs may change after this cycle. Then go to S_COMPUTE.
- S_COMPUTE: lasts K = L*N*E*L cycles.
  - Counter nesting, outer to inner: i, n, e, j.
  - Each cycle computes p = signed({1'b0,A[i][n][j]}) * signed(V[j][n][e]); p is 2*DATA_WIDTH+1 bits.
  - Accumulator is 2*DATA_WIDTH+$clog2(L)+1 bits and signed, so it never overflows.
  - When j < L-1: acc <= acc + p.
  - When j == L-1: r = (acc + p) >>> FRAC_BITS, an arithmetic shift that truncates toward negative infinity.
  - r is saturated to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1] and written to result[i][n][e]; acc <= 0 in the same cycle.
  - After the last (i,n,e,j) = (L-1,N-1,E-1,L-1), go to S_OUTPUT.
- S_OUTPUT: lasts 1 cycle. Pack the result array into out_mat. out_mat changes only in this state.
- S_DONE: lasts 1 cycle. done <= 1 and out_valid <= 1, then go to S_IDLE. done returns to 0 on the next edge.
- out_valid stays 1 until the next accepted start or reset.
- Latency: done is first seen high after edge K+3, counting the edge that sampled start as edge 0. Throughput is one operation per K+4 cycles.
- Reset mid-operation: immediately return to the reset values above. The partial result is discarded. A later start runs normally.
- A with a row sum of 0 (all-zero row) is legal and yields O row = 0.
- Counter widths are max(1,$clog2(X)). Counter wrap-around happens only at the defined terminal values.

Decomposition:
- Shared package attn_pkg:
  - typedef av_state_t (the 5 states).
  - localparams for product and accumulator widths.
  - function sat_shift(acc, FRAC_BITS, DATA_WIDTH) for shift plus saturation; reused by later attention stages.
- One sub-module, av_mac_sat (combinational):
  - inputs: a, v, acc_in, last.
  - outputs: acc_next, result.
  - contains the multiply, the add and sat_shift.
  - The FSM, counters and arrays stay in attention_av_multiply.

Test Plan (L=8, N=1, E=8, FRAC_BITS=8):
- Identity: A[i][0][i]=0x0100, all other A=0, V random -> out_mat == V bit-exact; done is a single pulse at edge K+3=515.
- Uniform weights: all A=0x0020 (1/8), all V=0x0800 (8.0) -> every O=0x0800.
- Saturation:
  - all A=0x0100, all V=0x7FFF -> every O=0x7FFF.
  - all V=0x8000 -> every O=0x8000.
- Negative truncation: A[0][0][0]=0x0080 (0.5), other A=0, V[0][0][0]=0xFFFD (-3), other V=0 -> O[0][0][0]=0xFFFE (floor(-1.5)=-2), all other O=0.
- Start handling:
  - start held high through S_COMPUTE -> exactly one done pulse.
  - out_valid=1 after done; it drops the cycle after a new start is accepted.
  - out_mat is unchanged until the next S_OUTPUT.
- Reset mid-operation: assert rst at cycle 200 of S_COMPUTE -> out_mat=0, done=0, out_valid=0 immediately. A new start with the identity vectors returns V after 515 edges.

Source files
------------

// File: rtl/attn_pkg.sv
// Shared types, width helpers and the fixed-point shift/saturate used by the attention stages.
package attn_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_COMPUTE = 3'd2,
    S_OUTPUT  = 3'd3,
    S_DONE    = 3'd4
  } av_state_t;

  // Working width for sat_shift; wide enough for any accumulator used here.
  localparam int unsigned SAT_W = 64;

  function automatic int unsigned prod_width(input int unsigned dw);
    return 2 * dw + 1;
  endfunction

  function automatic int unsigned acc_width(input int unsigned dw, input int unsigned l);
    return 2 * dw + $clog2(l) + 1;
  endfunction

  localparam int unsigned PROD_W_DEF = prod_width(16);
  localparam int unsigned ACC_W_DEF  = acc_width(16, 8);

  // Arithmetic right shift (floor) followed by saturation to a signed data_width range.
  function automatic logic signed [SAT_W-1:0] sat_shift(
    input logic signed [SAT_W-1:0] acc,
    input int unsigned             frac_bits,
    input int unsigned             data_width
  );
    logic signed [SAT_W-1:0] r;
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    r  = acc >>> frac_bits;
    hi = $signed((SAT_W'(1) << (data_width - 1)) - SAT_W'(1));
    lo = ~hi;
    if (r > hi) begin
      return hi;
    end else if (r < lo) begin
      return lo;
    end
    return r;
  endfunction

endpackage

// File: rtl/av_mac_sat.sv
// Combinational multiply-accumulate with shift/saturate on the last reduction step.
module av_mac_sat
  import attn_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned L          = 8,
  parameter int unsigned FRAC_BITS  = 8
) (
  input  logic [DATA_WIDTH-1:0]                       a,
  input  logic [DATA_WIDTH-1:0]                       v,
  input  logic signed [acc_width(DATA_WIDTH, L)-1:0]  acc_in,
  input  logic                                        last,
  output logic signed [acc_width(DATA_WIDTH, L)-1:0]  acc_next,
  output logic [DATA_WIDTH-1:0]                       result
);

  localparam int unsigned PROD_W = prod_width(DATA_WIDTH);
  localparam int unsigned ACC_W  = acc_width(DATA_WIDTH, L);

  logic signed [DATA_WIDTH:0]   a_s;
  logic signed [PROD_W-1:0]     p;
  logic signed [ACC_W-1:0]      sum;

  // Weight is unsigned, so it gets a zero sign bit before the signed multiply.
  always_comb begin
    a_s      = $signed({1'b0, a});
    p        = PROD_W'(a_s) * PROD_W'($signed(v));
    sum      = acc_in + ACC_W'(p);
    acc_next = last ? '0 : sum;
    result   = DATA_WIDTH'(sat_shift(SAT_W'(sum), FRAC_BITS, DATA_WIDTH));
  end

endmodule

// File: rtl/attention_av_multiply.sv
// Context O = A*V per head using a single sequential MAC driven by a small FSM.
module attention_av_multiply #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned L          = 8,
  parameter int unsigned N          = 1,
  parameter int unsigned E          = 8,
  parameter int unsigned FRAC_BITS  = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [DATA_WIDTH*L*N*L-1:0]    A_in,
  input  logic [DATA_WIDTH*L*N*E-1:0]    V_in,
  output logic [DATA_WIDTH*L*N*E-1:0]    out_mat,
  output logic                           done,
  output logic                           out_valid
);

  import attn_pkg::*;

  localparam int unsigned ACC_W = acc_width(DATA_WIDTH, L);
  localparam int unsigned IW    = (L > 1) ? $clog2(L) : 1;
  localparam int unsigned NW    = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned EW    = (E > 1) ? $clog2(E) : 1;

  av_state_t state;

  logic [IW-1:0] i_cnt;
  logic [IW-1:0] j_cnt;
  logic [NW-1:0] n_cnt;
  logic [EW-1:0] e_cnt;

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_next;

  logic [DATA_WIDTH*L*N*L-1:0] a_reg;
  logic [DATA_WIDTH*L*N*E-1:0] v_reg;
  logic [DATA_WIDTH*L*N*E-1:0] res_reg;

  logic [DATA_WIDTH-1:0] a_el;
  logic [DATA_WIDTH-1:0] v_el;
  logic [DATA_WIDTH-1:0] mac_res;
  logic                  last_j;
  logic                  last_all;
  int unsigned           a_idx;
  int unsigned           v_idx;
  int unsigned           o_idx;

  // Flat element indices for the current (i,n,e,j) and operand selection.
  always_comb begin
    a_idx    = (32'(i_cnt) * N + 32'(n_cnt)) * L + 32'(j_cnt);
    v_idx    = (32'(j_cnt) * N + 32'(n_cnt)) * E + 32'(e_cnt);
    o_idx    = (32'(i_cnt) * N + 32'(n_cnt)) * E + 32'(e_cnt);
    a_el     = a_reg[a_idx*DATA_WIDTH +: DATA_WIDTH];
    v_el     = v_reg[v_idx*DATA_WIDTH +: DATA_WIDTH];
    last_j   = (j_cnt == IW'(L - 1));
    last_all = last_j && (e_cnt == EW'(E - 1)) && (n_cnt == NW'(N - 1)) &&
               (i_cnt == IW'(L - 1));
  end

  av_mac_sat #(
    .DATA_WIDTH (DATA_WIDTH),
    .L          (L),
    .FRAC_BITS  (FRAC_BITS)
  ) u_mac (
    .a        (a_el),
    .v        (v_el),
    .acc_in   (acc),
    .last     (last_j),
    .acc_next (acc_next),
    .result   (mac_res)
  );

  // Operand capture and result storage; fully rewritten every run, so no reset needed.
  always_ff @(posedge clk) begin
    if (state == S_LOAD) begin
      a_reg <= A_in;
      v_reg <= V_in;
    end
    if (state == S_COMPUTE && last_j) begin
      res_reg[o_idx*DATA_WIDTH +: DATA_WIDTH] <= mac_res;
    end
  end

  // FSM, loop counters, accumulator and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      i_cnt     <= '0;
      j_cnt     <= '0;
      n_cnt     <= '0;
      e_cnt     <= '0;
      acc       <= '0;
      out_mat   <= '0;
      done      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_LOAD;
            out_valid <= 1'b0;
          end
        end
        S_LOAD: begin
          i_cnt <= '0;
          j_cnt <= '0;
          n_cnt <= '0;
          e_cnt <= '0;
          acc   <= '0;
          state <= S_COMPUTE;
        end
        S_COMPUTE: begin
          acc <= acc_next;
          if (last_j) begin
            j_cnt <= '0;
            if (e_cnt == EW'(E - 1)) begin
              e_cnt <= '0;
              if (n_cnt == NW'(N - 1)) begin
                n_cnt <= '0;
                if (i_cnt == IW'(L - 1)) begin
                  i_cnt <= '0;
                end else begin
                  i_cnt <= i_cnt + IW'(1);
                end
              end else begin
                n_cnt <= n_cnt + NW'(1);
              end
            end else begin
              e_cnt <= e_cnt + EW'(1);
            end
          end else begin
            j_cnt <= j_cnt + IW'(1);
          end
          if (last_all) begin
            state <= S_OUTPUT;
          end
        end
        S_OUTPUT: begin
          out_mat <= res_reg;
          state   <= S_DONE;
        end
        S_DONE: begin
          done      <= 1'b1;
          out_valid <= 1'b1;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_attention_av_multiply.sv
// Directed vector bench for attention_av_multiply (L=8, N=1, E=8, FRAC_BITS=8).
module tb_attention_av_multiply;

  localparam int unsigned DW  = 16;
  localparam int unsigned L   = 8;
  localparam int unsigned N   = 1;
  localparam int unsigned E   = 8;
  localparam int unsigned FB  = 8;
  localparam int unsigned W   = DW * L * N * L;
  localparam int          K   = L * N * E * L;
  localparam int          LAT = K + 3;
  localparam int          NV  = 6;

  typedef struct {
    string       name;
    logic [W-1:0] a;
    logic [W-1:0] v;
    logic [W-1:0] o;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] A_in;
  logic [W-1:0] V_in;
  logic [W-1:0] out_mat;
  logic         done;
  logic         out_valid;

  int total = 0;
  int bad   = 0;

  vec_t tbl[NV];

  always #5 clk = ~clk;

  attention_av_multiply #(
    .DATA_WIDTH (DW),
    .L          (L),
    .N          (N),
    .E          (E),
    .FRAC_BITS  (FB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .A_in      (A_in),
    .V_in      (V_in),
    .out_mat   (out_mat),
    .done      (done),
    .out_valid (out_valid)
  );

  task automatic chk_val(input string nm, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  task automatic chk_mat(input string nm, input logic [W-1:0] got, input logic [W-1:0] exp);
    int first;
    total++;
    if (got !== exp) begin
      bad++;
      first = -1;
      for (int k = 0; k < L * N * E; k++) begin
        if (first < 0 && got[k*DW +: DW] !== exp[k*DW +: DW]) first = k;
      end
      $display("FAIL %s elem=%0d got=%h exp=%h", nm, first,
               got[first*DW +: DW], exp[first*DW +: DW]);
    end
  endtask

  function automatic logic [W-1:0] fill(input logic [DW-1:0] val);
    logic [W-1:0] r;
    for (int k = 0; k < L * N * L; k++) r[k*DW +: DW] = val;
    return r;
  endfunction

  // One operation; inputs are scrambled after the load edge to prove capture.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] v, output int lat);
    @(negedge clk);
    A_in  = a;
    V_in  = v;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat   = -1;
    for (int c = 1; c <= K + 20; c++) begin
      @(posedge clk);
      #1;
      if (c == 1) begin
        A_in = ~a;
        V_in = ~v;
      end
      if (done) begin
        lat = c;
        break;
      end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    int pulses;
    int first_done;
    logic [W-1:0] prev;

    // Vector table: identity, row permutation, uniform, saturate high/low, negative floor.
    for (int t = 0; t < NV; t++) begin
      tbl[t].a = '0;
      tbl[t].v = '0;
      tbl[t].o = '0;
    end
    tbl[0].name = "identity";
    tbl[1].name = "permute";
    for (int k = 0; k < L * E; k++) begin
      tbl[0].v[k*DW +: DW] = DW'($urandom);
      tbl[1].v[k*DW +: DW] = DW'($urandom);
    end
    for (int i = 0; i < L; i++) begin
      tbl[0].a[(i*L + i)*DW +: DW]           = 16'h0100;
      tbl[1].a[(i*L + ((i + 1) % L))*DW +: DW] = 16'h0100;
      for (int e = 0; e < E; e++) begin
        tbl[1].o[(i*E + e)*DW +: DW] = tbl[1].v[(((i + 1) % L)*E + e)*DW +: DW];
      end
    end
    tbl[0].o = tbl[0].v;
    tbl[2].name = "uniform";
    tbl[2].a = fill(16'h0020);
    tbl[2].v = fill(16'h0800);
    tbl[2].o = fill(16'h0800);
    tbl[3].name = "sat_hi";
    tbl[3].a = fill(16'h0100);
    tbl[3].v = fill(16'h7FFF);
    tbl[3].o = fill(16'h7FFF);
    tbl[4].name = "sat_lo";
    tbl[4].a = fill(16'h0100);
    tbl[4].v = fill(16'h8000);
    tbl[4].o = fill(16'h8000);
    tbl[5].name = "neg_floor";
    tbl[5].a[0 +: DW] = 16'h0080;
    tbl[5].v[0 +: DW] = 16'hFFFD;
    tbl[5].o[0 +: DW] = 16'hFFFE;

    rst   = 1'b1;
    start = 1'b0;
    A_in  = '0;
    V_in  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_mat("reset_out_mat", out_mat, '0);
    chk_val("reset_done", int'(done), 0);
    chk_val("reset_out_valid", int'(out_valid), 0);
    @(negedge clk);
    rst = 1'b0;

    for (int t = 0; t < NV; t++) begin
      run_op(tbl[t].a, tbl[t].v, lat);
      chk_val({tbl[t].name, "_latency"}, lat, LAT);
      chk_mat({tbl[t].name, "_out"}, out_mat, tbl[t].o);
      chk_val({tbl[t].name, "_valid"}, int'(out_valid), 1);
      @(posedge clk);
      #1;
      chk_val({tbl[t].name, "_done_pulse"}, int'(done), 0);
    end

    // Idle: result and out_valid persist.
    prev = out_mat;
    repeat (5) @(posedge clk);
    #1;
    chk_val("idle_valid_hold", int'(out_valid), 1);
    chk_mat("idle_out_hold", out_mat, tbl[NV-1].o);

    // Start held high across compute: one done, out_valid drops after acceptance.
    @(negedge clk);
    A_in  = tbl[0].a;
    V_in  = tbl[0].v;
    start = 1'b1;
    @(posedge clk);
    #1;
    chk_val("valid_drop_on_start", int'(out_valid), 0);
    pulses     = 0;
    first_done = -1;
    for (int c = 1; c <= 600; c++) begin
      @(posedge clk);
      #1;
      if (c == 100) chk_mat("out_stable_in_compute", out_mat, prev);
      if (c == 300) start = 1'b0;
      if (done) begin
        pulses++;
        if (first_done < 0) first_done = c;
      end
    end
    chk_val("held_start_pulses", pulses, 1);
    chk_val("held_start_latency", first_done, LAT);
    chk_mat("held_start_out", out_mat, tbl[0].o);

    // Reset during compute cycle 200, then a clean rerun.
    @(negedge clk);
    A_in  = tbl[2].a;
    V_in  = tbl[2].v;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (201) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk_mat("midrst_out_mat", out_mat, '0);
    chk_val("midrst_done", int'(done), 0);
    chk_val("midrst_valid", int'(out_valid), 0);
    @(negedge clk);
    rst = 1'b0;
    run_op(tbl[0].a, tbl[0].v, lat);
    chk_val("after_rst_latency", lat, LAT);
    chk_mat("after_rst_out", out_mat, tbl[0].o);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
